// File: rtl/dla_regif_dma_cmdq.sv
// Multi-channel DDR<->GB DMA register interface with per-channel command FIFOs.
// Optional busy-cycle counter at sel 5 is built when DLA_DMA_CMDQ_PERF_EN is defined.
module dla_regif_dma_cmdq #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned DDR_AW = 54,
  parameter int unsigned GB_AW  = 13,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RIDX_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           regif_wen,
  input  logic [2:0]                     regif_ch,
  input  logic [2:0]                     regif_sel,
  input  logic [31:0]                    regif_wdata,
  output logic [31:0]                    regif_rdata,
  output logic [NUM_CH-1:0]              cmd_valid,
  input  logic [NUM_CH-1:0]              cmd_ready,
  output logic [NUM_CH-1:0][DDR_AW-1:0]  cmd_ddr_addr,
  output logic [NUM_CH-1:0][GB_AW-1:0]   cmd_gb_addr,
  output logic [NUM_CH-1:0]              cmd_ab_sel,
  output logic [NUM_CH-1:0][RIDX_W-1:0]  cmd_ramidx,
  output logic [NUM_CH-1:0]              cmd_dir,
  output logic [NUM_CH-1:0][LEN_W-1:0]   cmd_len,
  input  logic [NUM_CH-1:0]              cmd_done,
  output logic [NUM_CH-1:0]              irq
);

  localparam int unsigned A1W = DDR_AW - 32;
  localparam int unsigned DW  = DDR_AW + GB_AW + 1 + RIDX_W + LEN_W + 1;
  localparam int unsigned PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [7:0]  QD  = 8'(QDEPTH);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);

  logic [31:0] rdata_ch [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic sel_ch, wr_ctrl, wr_a0, wr_a1, wr_gb, wr_st, go;
    logic [31:0]      a0;
    logic [A1W-1:0]   a1;
    logic [GB_AW-1:0] gb_addr;
    logic             ab_sel, dir, irq_en;
    logic [RIDX_W-1:0] ramidx;
    logic [LEN_W-1:0] len;

    logic [DW-1:0]    mem [QDEPTH];
    logic [DW-1:0]    desc;
    logic [PW-1:0]    rptr, wptr;
    logic [7:0]       qcount, outstanding, done_cnt;
    logic             valid, pop, push, drop;
    logic             done_ok, spurious, done_flag, ovf, err, busy;
    logic [31:0]      perf_rd, rd;

    assign sel_ch  = (regif_ch == 3'(g));
    assign wr_ctrl = regif_wen && sel_ch && (regif_sel == 3'd0);
    assign wr_a0   = regif_wen && sel_ch && (regif_sel == 3'd1);
    assign wr_a1   = regif_wen && sel_ch && (regif_sel == 3'd2);
    assign wr_gb   = regif_wen && sel_ch && (regif_sel == 3'd3);
    assign wr_st   = regif_wen && sel_ch && (regif_sel == 3'd4);
    assign go      = wr_ctrl && regif_wdata[31];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a0      <= '0;
        a1      <= '0;
        gb_addr <= '0;
        ab_sel  <= 1'b0;
        ramidx  <= '0;
        len     <= '0;
        dir     <= 1'b0;
        irq_en  <= 1'b0;
      end else begin
        if (wr_a0) a0 <= regif_wdata;
        if (wr_a1) a1 <= regif_wdata[A1W-1:0];
        if (wr_gb) begin
          len     <= regif_wdata[24 +: LEN_W];
          ramidx  <= regif_wdata[20 +: RIDX_W];
          ab_sel  <= regif_wdata[13];
          gb_addr <= regif_wdata[GB_AW-1:0];
        end
        if (wr_ctrl) begin
          dir    <= regif_wdata[0];
          irq_en <= regif_wdata[1];
        end
      end
    end

    // Direction comes from the go write itself, not the stored dir bit.
    assign desc  = {a1, a0, gb_addr, ab_sel, ramidx, len, regif_wdata[0]};
    assign valid = (qcount != '0);
    assign pop   = valid && cmd_ready[g];
    assign push  = go && ((qcount < QD) || pop);
    assign drop  = go && !push;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rptr   <= '0;
        wptr   <= '0;
        qcount <= '0;
        for (int unsigned i = 0; i < QDEPTH; i++) mem[i] <= '0;
      end else begin
        if (push) begin
          mem[wptr] <= desc;
          wptr      <= (wptr == PLAST) ? '0 : wptr + 1'b1;
        end
        if (pop) rptr <= (rptr == PLAST) ? '0 : rptr + 1'b1;
        if (push && !pop)      qcount <= qcount + 8'd1;
        else if (pop && !push) qcount <= qcount - 8'd1;
      end
    end

    assign cmd_valid[g] = valid;
    assign {cmd_ddr_addr[g], cmd_gb_addr[g], cmd_ab_sel[g], cmd_ramidx[g],
            cmd_len[g], cmd_dir[g]} = valid ? mem[rptr] : '0;

    assign done_ok  = cmd_done[g] && (outstanding != '0);
    assign spurious = cmd_done[g] && (outstanding == '0);

    // Set events take priority over write-1-to-clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        outstanding <= '0;
        done_cnt    <= '0;
        done_flag   <= 1'b0;
        ovf         <= 1'b0;
        err         <= 1'b0;
      end else begin
        if (pop && !done_ok && (outstanding != 8'hFF)) outstanding <= outstanding + 8'd1;
        else if (done_ok && !pop)                      outstanding <= outstanding - 8'd1;
        if (done_ok) begin
          if (wr_st && regif_wdata[3])  done_cnt <= 8'd1;
          else if (done_cnt != 8'hFF)   done_cnt <= done_cnt + 8'd1;
        end else if (wr_st && regif_wdata[3]) begin
          done_cnt <= '0;
        end
        done_flag <= done_ok  || (done_flag && !(wr_st && regif_wdata[0]));
        ovf       <= drop     || (ovf       && !(wr_st && regif_wdata[1]));
        err       <= spurious || (err       && !(wr_st && regif_wdata[2]));
      end
    end

    assign busy   = valid || (outstanding != '0);
    assign irq[g] = irq_en && done_flag;

`ifdef DLA_DMA_CMDQ_PERF_EN
    logic [31:0] perf;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             perf <= '0;
      else if (regif_wen && sel_ch && regif_sel == 3'd5)   perf <= '0;
      else if (busy)                                       perf <= perf + 32'd1;
    end
    assign perf_rd = perf;
`else
    assign perf_rd = '0;
`endif

    always_comb begin
      rd = '0;
      case (regif_sel)
        3'd0: rd[1:0] = {irq_en, dir};
        3'd1: rd = a0;
        3'd2: rd[A1W-1:0] = a1;
        3'd3: begin
          rd[24 +: LEN_W]  = len;
          rd[20 +: RIDX_W] = ramidx;
          rd[13]           = ab_sel;
          rd[GB_AW-1:0]    = gb_addr;
        end
        3'd4: rd = {done_cnt, qcount, outstanding, 4'd0, err, ovf, done_flag, busy};
        3'd5: rd = perf_rd;
        default: rd = '0;
      endcase
    end
    assign rdata_ch[g] = rd;
  end

  always_comb begin
    regif_rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (regif_ch == 3'(c)) regif_rdata = rdata_ch[c];
  end

endmodule

// File: tb/tb_dla_regif_dma_cmdq.sv
// Directed self-checking bench for dla_regif_dma_cmdq (default parameters).
module tb_dla_regif_dma_cmdq;
  localparam int NUM_CH = 2;
  localparam int DDR_AW = 54;
  localparam int GB_AW  = 13;
  localparam int LEN_W  = 8;
  localparam int RIDX_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic regif_wen;
  logic [2:0] regif_ch, regif_sel;
  logic [31:0] regif_wdata, regif_rdata;
  logic [NUM_CH-1:0] cmd_valid, cmd_ready, cmd_ab_sel, cmd_dir, cmd_done, irq;
  logic [NUM_CH-1:0][DDR_AW-1:0] cmd_ddr_addr;
  logic [NUM_CH-1:0][GB_AW-1:0]  cmd_gb_addr;
  logic [NUM_CH-1:0][RIDX_W-1:0] cmd_ramidx;
  logic [NUM_CH-1:0][LEN_W-1:0]  cmd_len;

  int checks = 0;
  int errors = 0;

  dla_regif_dma_cmdq #(.NUM_CH(NUM_CH), .QDEPTH(4), .DDR_AW(DDR_AW), .GB_AW(GB_AW),
                       .LEN_W(LEN_W), .RIDX_W(RIDX_W)) dut (
    .clk(clk), .rst(rst), .regif_wen(regif_wen), .regif_ch(regif_ch),
    .regif_sel(regif_sel), .regif_wdata(regif_wdata), .regif_rdata(regif_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ddr_addr(cmd_ddr_addr),
    .cmd_gb_addr(cmd_gb_addr), .cmd_ab_sel(cmd_ab_sel), .cmd_ramidx(cmd_ramidx),
    .cmd_dir(cmd_dir), .cmd_len(cmd_len), .cmd_done(cmd_done), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wen;
    logic [2:0]  wch, wsel;
    logic [31:0] wdata;
    logic [2:0]  rch, rsel;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [2:0] sel, input logic [31:0] d);
    regif_wen = 1'b1; regif_ch = ch; regif_sel = sel; regif_wdata = d;
    @(negedge clk);
    regif_wen = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] ch, input logic [2:0] sel,
                        input logic [31:0] exp);
    regif_ch = ch; regif_sel = sel;
    #1;
    chk(nm, regif_rdata, exp);
  endtask

  vec_t vecs[17];
  int unsigned exp_perf;

  initial begin
    rst = 1'b1; regif_wen = 1'b0; regif_ch = '0; regif_sel = '0; regif_wdata = '0;
    cmd_ready = '0; cmd_done = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ddr_addr", cmd_ddr_addr[0], 0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0]  = '{"rst_status0", 0, 0, 0, 0,            0, 4, 32'h0};
    vecs[1]  = '{"rst_status1", 0, 0, 0, 0,            1, 4, 32'h0};
    vecs[2]  = '{"addr0",       1, 0, 1, 32'h1000_0000, 0, 1, 32'h1000_0000};
    vecs[3]  = '{"addr1_mask",  1, 0, 2, 32'hFFFF_FFFF, 0, 2, 32'h003F_FFFF};
    vecs[4]  = '{"gbaddr_mask", 1, 0, 3, 32'hFFFF_FFFF, 0, 3, 32'hFFF0_3FFF};
    vecs[5]  = '{"ctrl_rw",     1, 0, 0, 32'h0000_0003, 0, 0, 32'h0000_0003};
    vecs[6]  = '{"ctrl_unused", 1, 0, 0, 32'h7FFF_FFFC, 0, 0, 32'h0};
    vecs[7]  = '{"ch1_addr0",   1, 1, 1, 32'hDEAD_BEEF, 1, 1, 32'hDEAD_BEEF};
    vecs[8]  = '{"ch0_isol",    0, 0, 0, 0,            0, 1, 32'h1000_0000};
    vecs[9]  = '{"ch7_ignored", 1, 7, 1, 32'h1234_5678, 7, 1, 32'h0};
    vecs[10] = '{"sel6_zero",   0, 0, 0, 0,            0, 6, 32'h0};
    vecs[11] = '{"perf_idle",   0, 0, 0, 0,            0, 5, 32'h0};
    vecs[12] = '{"addr1",       1, 0, 2, 32'h0000_0003, 0, 2, 32'h0000_0003};
    vecs[13] = '{"gbaddr",      1, 0, 3, 32'h10A0_2005, 0, 3, 32'h10A0_2005};
    vecs[14] = '{"ch1_gbaddr",  1, 1, 3, 32'h0350_1FFF, 1, 3, 32'h0350_1FFF};
    vecs[15] = '{"ch1_addr1",   1, 1, 2, 32'h0000_0001, 1, 2, 32'h0000_0001};
    vecs[16] = '{"ch1_nopush",  0, 0, 0, 0,            1, 4, 32'h0};

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wen) wr(vecs[i].wch, vecs[i].wsel, vecs[i].wdata);
      rd_chk(vecs[i].name, vecs[i].rch, vecs[i].rsel, vecs[i].exp);
    end
    chk("no_push_valid", cmd_valid, 0);

    // Queue and drain
    wr(0, 0, 32'h8000_0001);
    chk("q_valid", cmd_valid[0], 1);
    chk("q_ddr", cmd_ddr_addr[0], 54'h3_1000_0000);
    chk("q_len", cmd_len[0], 8'h10);
    chk("q_ramidx", cmd_ramidx[0], 4'hA);
    chk("q_absel", cmd_ab_sel[0], 1);
    chk("q_gb", cmd_gb_addr[0], 13'h0005);
    chk("q_dir", cmd_dir[0], 1);
    rd_chk("q_status", 0, 4, 32'h0001_0001);
    cmd_ready[0] = 1'b1; @(negedge clk); cmd_ready[0] = 1'b0;
    rd_chk("drain_status", 0, 4, 32'h0000_0101);
    chk("drain_valid", cmd_valid[0], 0);

    // Completion and irq
    wr(0, 0, 32'h0000_0002);
    cmd_done[0] = 1'b1; @(negedge clk); cmd_done[0] = 1'b0;
    rd_chk("done_status", 0, 4, 32'h0100_0002);
    chk("irq_set", irq, 2'b01);
    wr(0, 4, 32'h1);
    chk("irq_clr", irq, 0);
    rd_chk("flag_clr_status", 0, 4, 32'h0100_0000);
    wr(0, 4, 32'h8);
    rd_chk("cnt_clr_status", 0, 4, 32'h0);

    // Spurious done
    cmd_done[0] = 1'b1; @(negedge clk); cmd_done[0] = 1'b0;
    rd_chk("spurious_err", 0, 4, 32'h0000_0008);
    wr(0, 4, 32'h4);

    // Pop and done in the same cycle
    wr(0, 0, 32'h8000_0002);
    cmd_ready[0] = 1'b1; @(negedge clk); cmd_ready[0] = 1'b0;
    wr(0, 0, 32'h8000_0002);
    cmd_ready[0] = 1'b1; cmd_done[0] = 1'b1; @(negedge clk);
    cmd_ready[0] = 1'b0; cmd_done[0] = 1'b0;
    rd_chk("pop_done_status", 0, 4, 32'h0100_0103);
    cmd_done[0] = 1'b1; @(negedge clk); cmd_done[0] = 1'b0;
    rd_chk("final_done_status", 0, 4, 32'h0200_0002);
    wr(0, 4, 32'hF);

    // Set beats clear: done_cnt 1 -> done+clear -> 1, flag stays 1
    wr(0, 0, 32'h8000_0002);
    cmd_ready[0] = 1'b1; @(negedge clk); cmd_ready[0] = 1'b0;
    cmd_done[0] = 1'b1; @(negedge clk); cmd_done[0] = 1'b0;
    wr(0, 0, 32'h8000_0002);
    cmd_ready[0] = 1'b1; @(negedge clk); cmd_ready[0] = 1'b0;
    cmd_done[0] = 1'b1;
    wr(0, 4, 32'h9);
    cmd_done[0] = 1'b0;
    rd_chk("set_wins_status", 0, 4, 32'h0100_0002);
    wr(0, 4, 32'hF);
    rd_chk("clr_all_status", 0, 4, 32'h0);

    // Overflow: 5 pushes into depth 4, lengths 1..5
    for (int k = 1; k <= 5; k++) begin
      wr(0, 3, 32'(k) << 24);
      wr(0, 0, 32'h8000_0000);
    end
    rd_chk("ovf_status", 0, 4, 32'h0004_0005);
    wr(0, 4, 32'h2);
    wr(0, 3, 32'h0600_0000);
    chk("full_head_len", cmd_len[0], 8'd1);
    cmd_ready[0] = 1'b1;
    wr(0, 0, 32'h8000_0000);
    cmd_ready[0] = 1'b0;
    rd_chk("full_pop_push_status", 0, 4, 32'h0004_0101);
    begin
      logic [7:0] exp_len [4];
      exp_len = '{8'd2, 8'd3, 8'd4, 8'd6};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("drain_valid_%0d", k), cmd_valid[0], 1);
        chk($sformatf("drain_len_%0d", k), cmd_len[0], exp_len[k]);
        cmd_ready[0] = 1'b1; @(negedge clk); cmd_ready[0] = 1'b0;
      end
    end
    rd_chk("drained_status", 0, 4, 32'h0000_0501);
    chk("drained_valid", cmd_valid[0], 0);

    // Channel independence
    cmd_ready[1] = 1'b1;
    wr(0, 0, 32'h8000_0000);
    wr(1, 0, 32'h8000_0001);
    wr(0, 0, 32'h8000_0000);
    wr(1, 0, 32'h8000_0001);
    chk("ch1_valid", cmd_valid[1], 1);
    chk("ch1_ddr", cmd_ddr_addr[1], 54'h1_DEAD_BEEF);
    chk("ch1_len", cmd_len[1], 8'h03);
    chk("ch1_ramidx", cmd_ramidx[1], 4'h5);
    chk("ch1_gb", cmd_gb_addr[1], 13'h1FFF);
    chk("ch1_dir", cmd_dir[1], 1);
    @(negedge clk);
    cmd_ready[1] = 1'b0;
    rd_chk("ch0_indep_status", 0, 4, 32'h0002_0501);
    rd_chk("ch1_indep_status", 1, 4, 32'h0000_0201);
    rd_chk("ch7_status", 7, 4, 32'h0);
    chk("indep_irq", irq, 0);

    // Reset mid-queue
    wr(0, 0, 32'h8000_0000);
    rd_chk("pre_rst_status", 0, 4, 32'h0003_0501);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", cmd_valid, 0);
    chk("async_rst_len", cmd_len[0], 0);
    rd_chk("async_rst_status0", 0, 4, 32'h0);
    rd_chk("async_rst_status1", 1, 4, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Busy-cycle counter (reads 0 when not built)
    wr(0, 0, 32'h8000_0000);
    repeat (10) @(negedge clk);
`ifdef DLA_DMA_CMDQ_PERF_EN
    exp_perf = 10;
`else
    exp_perf = 0;
`endif
    rd_chk("perf_10", 0, 5, exp_perf);
    wr(0, 5, 32'h0);
    rd_chk("perf_clr", 0, 5, 32'h0);
    repeat (3) @(negedge clk);
`ifdef DLA_DMA_CMDQ_PERF_EN
    exp_perf = 3;
`else
    exp_perf = 0;
`endif
    rd_chk("perf_3", 0, 5, exp_perf);
    #2 rst = 1'b1;
    #1;
    rd_chk("perf_rst", 0, 5, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
